retire_rrat: RTL and testbench

- Retirement-side counterpart of rename: consumes in-order commits from the ROB head and maintains the retirement register alias table (RRAT, 32 arch -> 6-bit phys).
- Returns each superseded physical register to the rename freelist via rrat_free / rrat_free_reg.
- Exports rrat_map for freelist rebuild and FRAT restore on flush.
- Buffers returns in a small FIFO so commit is not lost while the freelist is stalled.

---
 rtl/retire_rrat.sv | 175 +++++++++++++++++
 tb/tb_retire_rrat.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/retire_rrat.sv
// Retirement register alias table: applies in-order commits, queues superseded
// physical registers for the freelist, and drives FRAT restore after a flush.
// Optional macro RETIRE_STATS_EN enables the retire_count counter and a per-cycle trace.
module retire_rrat #(
    parameter int FREE_Q_DEPTH = 4,
    parameter int CW           = $clog2(FREE_Q_DEPTH + 1)
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          STALL,
    input  logic          FLUSH,
    input  logic          rob_commit,
    input  logic          rob_commit_regwr,
    input  logic [4:0]    rob_commit_areg,
    input  logic [5:0]    rob_commit_preg,
    output logic          retire_halt,
    output logic          rrat_free,
    output logic [5:0]    rrat_free_reg,
    output logic [5:0]    rrat_map [31:0],
    output logic          frat_restore,
    output logic [CW-1:0] free_q_count,
    output logic [31:0]   retire_count
);

    localparam int PW = (FREE_Q_DEPTH > 1) ? $clog2(FREE_Q_DEPTH) : 1;

    typedef enum logic {
        ST_NORMAL,
        ST_RESTORE
    } state_t;

    state_t          state_q, state_d;
    logic [5:0]      map_q [31:0];
    logic [5:0]      map_d [31:0];
    logic [5:0]      fifo_q [FREE_Q_DEPTH];
    logic [5:0]      fifo_d [FREE_Q_DEPTH];
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic            free_q, free_d;
    logic [5:0]      free_reg_q, free_reg_d;
    logic            restore_q, restore_d;

    logic            fifo_full;
    logic            commit_ok;
    logic            wr_en;
    logic            enq;
    logic            deq;
    logic [5:0]      old_preg;

    // A full FIFO refuses the commit even when it also drains this cycle.
    assign fifo_full   = (count_q == CW'(FREE_Q_DEPTH));
    assign retire_halt = FLUSH | (state_q == ST_RESTORE) | fifo_full;
    assign commit_ok   = rob_commit & ~retire_halt;
    assign wr_en       = commit_ok & rob_commit_regwr & (rob_commit_areg != 5'd0);
    assign old_preg    = map_q[rob_commit_areg];
    assign enq         = wr_en & (old_preg != 6'd0);
    assign deq         = (count_q != '0) & ~STALL & ~FLUSH & (state_q == ST_NORMAL);

    always_comb begin
        state_d    = state_q;
        map_d      = map_q;
        fifo_d     = fifo_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        free_d     = 1'b0;
        free_reg_d = free_reg_q;
        restore_d  = 1'b0;

        if (deq) begin
            free_d     = 1'b1;
            free_reg_d = fifo_q[head_q];
            head_d     = head_q + 1'b1;
        end
        if (wr_en) begin
            map_d[rob_commit_areg] = rob_commit_preg;
        end
        if (enq) begin
            fifo_d[tail_q] = old_preg;
            tail_d         = tail_q + 1'b1;
        end
        case ({enq, deq})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // Pending frees are dropped on flush; freelist rebuild from rrat_map recovers them.
        case (state_q)
            ST_NORMAL: begin
                if (FLUSH) begin
                    state_d = ST_RESTORE;
                    head_d  = '0;
                    tail_d  = '0;
                    count_d = '0;
                    free_d  = 1'b0;
                end
            end
            ST_RESTORE: begin
                if (!FLUSH) begin
                    restore_d = 1'b1;
                    state_d   = ST_NORMAL;
                end
            end
            default: state_d = ST_NORMAL;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= ST_NORMAL;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            free_q     <= 1'b0;
            free_reg_q <= 6'd0;
            restore_q  <= 1'b0;
            for (int i = 0; i < 32; i++) begin
                map_q[i] <= 6'(i);
            end
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            free_q     <= free_d;
            free_reg_q <= free_reg_d;
            restore_q  <= restore_d;
            map_q      <= map_d;
        end
    end

    // FIFO storage carries data only; validity comes from count/pointers.
    always_ff @(posedge CLK) begin
        fifo_q <= fifo_d;
    end

    assign rrat_map      = map_q;
    assign rrat_free     = free_q;
    assign rrat_free_reg = free_reg_q;
    assign frat_restore  = restore_q;
    assign free_q_count  = count_q;

`ifdef RETIRE_STATS_EN
    logic [31:0] retire_count_q, retire_count_d;

    always_comb begin
        retire_count_d = retire_count_q;
        if (commit_ok) begin
            retire_count_d = retire_count_q + 32'd1;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            retire_count_q <= '0;
        end else begin
            retire_count_q <= retire_count_d;
        end
    end

    always @(posedge CLK) begin
        if (RESET) begin
            $display("RRAT commit=%0b areg=%0d preg=%0d free=%0b free_reg=%0d q_count=%0d",
                     commit_ok, rob_commit_areg, rob_commit_preg, free_q, free_reg_q, count_q);
        end
    end

    assign retire_count = retire_count_q;
`else
    assign retire_count = 32'd0;
`endif

endmodule

// File: tb/tb_retire_rrat.sv
// Randomized self-checking bench for retire_rrat against a queue-based reference model.
module tb_retire_rrat;

    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic          CLK;
    logic          RESET;
    logic          STALL;
    logic          FLUSH;
    logic          rob_commit;
    logic          rob_commit_regwr;
    logic [4:0]    rob_commit_areg;
    logic [5:0]    rob_commit_preg;
    logic          retire_halt;
    logic          rrat_free;
    logic [5:0]    rrat_free_reg;
    logic [5:0]    rrat_map [31:0];
    logic          frat_restore;
    logic [CW-1:0] free_q_count;
    logic [31:0]   retire_count;

    retire_rrat #(.FREE_Q_DEPTH(DEPTH), .CW(CW)) dut (
        .CLK              (CLK),
        .RESET            (RESET),
        .STALL            (STALL),
        .FLUSH            (FLUSH),
        .rob_commit       (rob_commit),
        .rob_commit_regwr (rob_commit_regwr),
        .rob_commit_areg  (rob_commit_areg),
        .rob_commit_preg  (rob_commit_preg),
        .retire_halt      (retire_halt),
        .rrat_free        (rrat_free),
        .rrat_free_reg    (rrat_free_reg),
        .rrat_map         (rrat_map),
        .frat_restore     (frat_restore),
        .free_q_count     (free_q_count),
        .retire_count     (retire_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: architectural map, FIFO of pending frees, flush state.
    int mmap [32];
    int pend [$];
    bit m_restore;
    bit m_free;
    int m_free_reg;
    bit m_frat;
    int m_retired;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int exp_retire_count();
`ifdef RETIRE_STATS_EN
        return m_retired;
`else
        return 0;
`endif
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mmap[i] = i;
        pend.delete();
        m_restore  = 1'b0;
        m_free     = 1'b0;
        m_free_reg = 0;
        m_frat     = 1'b0;
        m_retired  = 0;
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_free"}, {31'd0, rrat_free}, m_free);
        chk({tag, "_free_reg"}, {26'd0, rrat_free_reg}, m_free_reg);
        chk({tag, "_count"}, {29'd0, free_q_count}, pend.size());
        chk({tag, "_frat_restore"}, {31'd0, frat_restore}, m_frat);
        chk({tag, "_retire_count"}, retire_count, exp_retire_count());
        for (int i = 0; i < 32; i++) begin
            chk($sformatf("%s_map%0d", tag, i), {26'd0, rrat_map[i]}, mmap[i]);
        end
    endtask

    // One clock: drive at negedge, check halt, advance model, check after posedge.
    task automatic cycle(input bit c, input bit rw, input int a, input int p,
                         input bit st, input bit fl, input string tag);
        bit halt, acc, dq;
        int old;
        @(negedge CLK);
        rob_commit       = c;
        rob_commit_regwr = rw;
        rob_commit_areg  = 5'(a);
        rob_commit_preg  = 6'(p);
        STALL            = st;
        FLUSH            = fl;
        #1;
        halt = fl || m_restore || (pend.size() == DEPTH);
        chk({tag, "_halt"}, {31'd0, retire_halt}, halt);
        acc = c && !halt;
        dq  = (pend.size() != 0) && !st && !fl && !m_restore;
        m_free = dq;
        if (dq) m_free_reg = pend.pop_front();
        if (acc) m_retired++;
        if (acc && rw && a != 0) begin
            old     = mmap[a];
            mmap[a] = p;
            if (old != 0) pend.push_back(old);
        end
        m_frat = 1'b0;
        if (!m_restore && fl) begin
            pend.delete();
            m_restore = 1'b1;
        end else if (m_restore && !fl) begin
            m_frat    = 1'b1;
            m_restore = 1'b0;
        end
        @(posedge CLK);
        #1;
        check_state(tag);
    endtask

    task automatic idle(input int n, input string tag);
        for (int k = 0; k < n; k++) cycle(0, 0, 0, 0, 0, 0, tag);
    endtask

    initial begin
        RESET = 1'b0;
        STALL = 1'b0;
        FLUSH = 1'b0;
        rob_commit = 1'b0;
        rob_commit_regwr = 1'b0;
        rob_commit_areg = 5'd0;
        rob_commit_preg = 6'd0;
        model_reset();
        #12;
        check_state("reset");
        chk("reset_halt", {31'd0, retire_halt}, 0);
        @(negedge CLK);
        RESET = 1'b1;

        // Single commit: map updates at the edge, the old mapping frees one edge later.
        cycle(1, 1, 5, 40, 0, 0, "t2_commit");
        chk("t2_map5", {26'd0, rrat_map[5]}, 40);
        chk("t2_no_free_yet", {31'd0, rrat_free}, 0);
        idle(1, "t2_drain");
        chk("t2_free", {31'd0, rrat_free}, 1);
        chk("t2_free_reg", {26'd0, rrat_free_reg}, 5);
        idle(1, "t2_after");
        chk("t2_free_low", {31'd0, rrat_free}, 0);

        // Non-writing commits.
        cycle(1, 1, 0, 33, 0, 0, "t3_areg0");
        cycle(1, 0, 7, 50, 0, 0, "t3_noregwr");
        idle(1, "t3_idle");

        // Fill under stall, fifth commit refused, then drain in order.
        for (int i = 1; i <= 4; i++) cycle(1, 1, i, 31 + i, 1, 0, "t4_fill");
        chk("t4_full_halt", {31'd0, retire_halt}, 1);
        cycle(1, 1, 9, 60, 1, 0, "t4_refused");
        chk("t4_map9", {26'd0, rrat_map[9]}, 9);
        for (int i = 1; i <= 4; i++) begin
            idle(1, "t4_drain");
            chk($sformatf("t4_free_reg%0d", i), {26'd0, rrat_free_reg}, i);
        end
        idle(1, "t4_done");

        // Flush with three pending entries and commits presented during flush.
        for (int i = 10; i < 13; i++) cycle(1, 1, i, 40 + i, 1, 0, "t5_fill");
        cycle(1, 1, 20, 61, 0, 1, "t5_flush");
        cycle(1, 1, 21, 62, 0, 1, "t5_flush");
        chk("t5_count", {29'd0, free_q_count}, 0);
        cycle(1, 1, 22, 63, 0, 0, "t5_release");
        chk("t5_frat_restore", {31'd0, frat_restore}, 1);
        idle(2, "t5_after");

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0,
                  $urandom_range(0, 31), $urandom_range(0, 63),
                  $urandom_range(0, 2) == 0, $urandom_range(0, 19) == 0, "rnd");
        end

        // Asynchronous reset in the middle of a flush.
        cycle(1, 1, 3, 44, 0, 1, "mid_flush");
        @(negedge CLK);
        FLUSH = 1'b0;
        rob_commit = 1'b0;
        #2;
        RESET = 1'b0;
        #1;
        model_reset();
        check_state("mid_reset");
        chk("mid_reset_halt", {31'd0, retire_halt}, 0);
        @(negedge CLK);
        RESET = 1'b1;
        cycle(1, 1, 6, 45, 0, 0, "post_reset");
        idle(2, "post_reset_drain");

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
